dtc_vote_accumulator: RTL and testbench
=======================================

// Module: dtc_vote_accumulator
// PURPOSE
//  Downstream stage of the dtc_* decision-tree classifiers. Consumes the 2-bit class
//  code produced per feature vector, accumulates a per-class histogram over a window
//  of WIN accepted samples (or a flushed partial window), and emits the majority class
//  with its vote count over a valid/ready handshake.
// PARAMETERS
//  WIN   8   samples per voting window; legal range 1..255
//  CW    $clog2(WIN+1)   derived (localparam) width of every count field
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   in_class valid this cycle
//  in_ready   out  1   stage accepts a sample this cycle
//  in_class   in   2   class code from the classifier (0..3)
//  flush      in   1   single-cycle request: close the current window early
//  out_valid  out  1   result valid; held until out_ready
//  out_ready  in   1   downstream accepts result
//  out_class  out  2   majority class of the closed window
//  out_count  out  CW  votes received by out_class
//  out_total  out  CW  samples in the closed window (WIN, or fewer on flush)
// BEHAVIOUR
//  - Reset (async, rst=1): state=ACCUM, cnt[0..3]=0, total=0, out_valid=0,
//    out_class=0, out_count=0, out_total=0. in_ready=1 once rst is released.
//  - Accept = in_valid & in_ready. in_ready = (state==ACCUM), combinational from state only.
//  - FSM ACCUM: each accept increments cnt[in_class] and total.
//    close = (accept & total==WIN-1) | (flush & (total!=0 | accept)).
//    On close: argmax over next-state counts (the current sample included) is latched into
//    out_class/out_count, next-state total into out_total; cnt/total cleared; ->EMIT.
//  - FSM EMIT: out_valid=1, in_ready=0, out_* stable. On out_ready: out_valid=0 next
//    cycle; ->ACCUM. Latency: out_valid rises the cycle after the closing accept/flush.
//  - Argmax tie-break: the lowest class index wins (e.g. cnt0==cnt1 max -> class 0).
//  - Flush on an empty window (total==0, no accept) is ignored; no output is produced.
//  - Flush while in EMIT is ignored (no queuing). A flush coinciding with the WIN-th
//    accept closes exactly one window with out_total=WIN.
//  - Counts never wrap: total<=WIN by construction; cnt[k]<=total.
//  - rst asserted mid-window or in EMIT discards partial counts and any pending result.
//  - out_* registered; no combinational path in->out except in_ready<-state.
// TESTING (WIN=8)
//  1 8 accepts: 5x class2, 3x class3 -> next cycle out_valid=1, class=2, count=5, total=8
//  2 Tie 4x class1, 4x class0 -> out_class=0, out_count=4; tie 2-2-2-2 -> class 0, count 2
//  3 Hold out_ready=0 for 5 cycles in EMIT with in_valid=1 -> in_ready=0, out_* constant,
//    no sample counted; after out_ready=1 the next window starts from zero counts
//  4 3x class1 then flush -> out_class=1, out_count=3, out_total=3; flush at total=0 ->
//    out_valid stays 0
//  5 Flush together with 3rd accept (class3 after 2x class3) -> count=3, total=3
//  6 3 accepts, rst pulse mid-cycle, then 8x class3 -> single result class=3, count=8

Source files
------------

// File: rtl/dtc_vote_accumulator.sv
// Majority vote over a window of classifier decisions: a per-class histogram is built
// over WIN accepted samples (or a flushed partial window), then the winner is emitted.
module dtc_vote_accumulator #(
    parameter  int WIN = 8,
    localparam int CW  = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_class,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    out_class,
    output logic [CW-1:0] out_count,
    output logic [CW-1:0] out_total,
    output logic          dbg_state
);

    // Handshake: a sample transfers on a rising edge where in_valid & in_ready;
    // a result transfers where out_valid & out_ready. out_valid and out_* stay
    // stable until that transfer, and in_ready depends on state only.

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt [4];
    logic [CW-1:0] w_cnt_nxt [4];
    logic [CW-1:0] r_total;
    logic [CW-1:0] w_total_nxt;
    logic          w_accept;
    logic          w_close;
    logic [1:0]    w_win_class;
    logic [CW-1:0] w_win_count;

    logic          r_out_valid;
    logic [1:0]    r_out_class;
    logic [CW-1:0] r_out_count;
    logic [CW-1:0] r_out_total;

    always_comb begin
        w_accept    = in_valid & (r_state == ST_ACCUM);
        w_total_nxt = r_total + CW'(w_accept);
        for (int k = 0; k < 4; k++) begin
            w_cnt_nxt[k] = r_cnt[k] + CW'(w_accept && (in_class == 2'(k)));
        end
    end

    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        w_win_class = 2'd0;
        w_win_count = w_cnt_nxt[0];
        for (int k = 1; k < 4; k++) begin
            if (w_cnt_nxt[k] > w_win_count) begin
                w_win_class = 2'(k);
                w_win_count = w_cnt_nxt[k];
            end
        end
    end

    always_comb begin
        w_close = (r_state == ST_ACCUM) &&
                  ((w_accept && (r_total == CW'(WIN - 1))) ||
                   (flush && ((r_total != '0) || w_accept)));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_close)   w_state_nxt = ST_EMIT;
            ST_EMIT:  if (out_ready) w_state_nxt = ST_ACCUM;
            default:                 w_state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
            r_total <= '0;
        end else if (w_close) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
            r_total <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < 4; k++) r_cnt[k] <= w_cnt_nxt[k];
            r_total <= w_total_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_class <= 2'd0;
            r_out_count <= '0;
            r_out_total <= '0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_class <= w_win_class;
            r_out_count <= w_win_count;
            r_out_total <= w_total_nxt;
        end else if ((r_state == ST_EMIT) && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = r_out_valid;
    assign out_class = r_out_class;
    assign out_count = r_out_count;
    assign out_total = r_out_total;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
// Bench for dtc_vote_accumulator (WIN=8): directed windows plus random windows,
// results checked against an expected queue of {class, count, total}.
module tb_dtc_vote_accumulator;

    localparam int WIN = 8;
    localparam int CW  = $clog2(WIN + 1);
    localparam int EW  = 2 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_class = 2'd0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_class;
    logic [CW-1:0] out_count;
    logic [CW-1:0] out_total;
    logic          dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    dtc_vote_accumulator #(.WIN(WIN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .out_total (out_total),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: every completed result transfer pops one expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got class=%0d count=%0d total=%0d, required none",
                         out_class, out_count, out_total);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({out_class, out_count, out_total} !== e) begin
                    errors++;
                    $display("FAIL result: got class=%0d count=%0d total=%0d, required class=%0d count=%0d total=%0d",
                             out_class, out_count, out_total,
                             e[EW-1 -: 2], e[2*CW-1 -: CW], e[CW-1:0]);
                end
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic send(input logic [1:0] c, input logic f);
        in_valid = 1'b1;
        in_class = c;
        flush    = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] c, input int cnt, input int tot);
        exp_q.push_back({c, CW'(cnt), CW'(tot)});
    endtask

    task automatic take_result(input string name);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got out_valid=%b, required 1", name, out_valid);
        end else begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_release: got out_valid=%b in_ready=%b, required 0 1",
                         name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_class !== 2'd0 || out_count !== '0 || out_total !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b c=%0d n=%0d t=%0d, required 0 0 0 0",
                     out_valid, out_class, out_count, out_total);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_window();
        for (int i = 0; i < 5; i++) send(2'd2, 1'b0);
        for (int i = 0; i < 2; i++) send(2'd3, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_early: got out_valid=%b, required 0", out_valid);
        end
        push_exp(2'd2, 5, 8);
        send(2'd3, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_latency: got out_valid=%b, required 1", out_valid);
        end
        take_result("full");
    endtask

    task automatic test_ties();
        push_exp(2'd0, 4, 8);
        for (int i = 0; i < 4; i++) send(2'd1, 1'b0);
        for (int i = 0; i < 4; i++) send(2'd0, 1'b0);
        take_result("tie_2way");
        push_exp(2'd0, 2, 8);
        for (int i = 0; i < 8; i++) send(2'(3 - (i % 4)), 1'b0);
        take_result("tie_4way");
        push_exp(2'd2, 4, 8);
        for (int i = 0; i < 8; i++) send((i % 2) ? 2'd3 : 2'd2, 1'b0);
        take_result("tie_hi");
    endtask

    task automatic test_hold();
        push_exp(2'd1, 6, 8);
        for (int i = 0; i < 6; i++) send(2'd1, 1'b0);
        send(2'd0, 1'b0);
        send(2'd3, 1'b0);
        in_valid = 1'b1;
        in_class = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== 2'd1 ||
                out_count !== CW'(6) || out_total !== CW'(8)) begin
                errors++;
                $display("FAIL hold_cycle%0d: got rdy=%b v=%b c=%0d n=%0d t=%0d, required 0 1 1 6 8",
                         i, in_ready, out_valid, out_class, out_count, out_total);
            end
        end
        in_valid = 1'b0;
        take_result("hold");
        push_exp(2'd0, 1, 1);
        send(2'd0, 1'b1);
        take_result("hold_fresh");
    endtask

    task automatic test_flush();
        push_exp(2'd1, 3, 3);
        for (int i = 0; i < 3; i++) send(2'd1, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_latency: got out_valid=%b, required 1", out_valid);
        end
        take_result("flush_partial");
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty: got out_valid=%b, required 0", out_valid);
            end
        end
        push_exp(2'd3, 3, 3);
        send(2'd3, 1'b0);
        send(2'd3, 1'b0);
        send(2'd3, 1'b1);
        take_result("flush_with_accept");
    endtask

    task automatic test_flush_boundaries();
        push_exp(2'd0, 7, 8);
        for (int i = 0; i < 7; i++) send(2'd0, 1'b0);
        send(2'd2, 1'b1);
        // flush during EMIT must not queue another window
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        take_result("flush_at_win");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_extra: got out_valid=%b, required 0", out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) send(2'd1, 1'b0);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        push_exp(2'd3, 8, 8);
        for (int i = 0; i < 8; i++) send(2'd3, 1'b0);
        take_result("reset_mid");
        // result pending in EMIT is discarded by reset
        for (int i = 0; i < 8; i++) send(2'd2, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_total !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_emit: got v=%b t=%0d rdy=%b, required 0 0 1",
                     out_valid, out_total, in_ready);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 12; w++) begin
            int len;
            int cnt[4];
            int best;
            logic [1:0] c;
            len = $urandom_range(1, WIN);
            for (int k = 0; k < 4; k++) cnt[k] = 0;
            for (int i = 0; i < len; i++) begin
                c = 2'($urandom_range(0, 3));
                cnt[c]++;
                if (i == len - 1) begin
                    best = 0;
                    for (int k = 1; k < 4; k++) if (cnt[k] > cnt[best]) best = k;
                    push_exp(2'(best), cnt[best], len);
                end
                send(c, (i == len - 1) && (len < WIN || $urandom_range(0, 1) == 1));
            end
            take_result("random");
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_ties();
        test_hold();
        test_flush();
        test_flush_boundaries();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
